hilo_sequencer: RTL

//  Multi-cycle multiply/divide sequencer owning the HI/LO registers for EX1.

---
 rtl/hilo_pkg.sv | 24 ++
 rtl/md_divider.sv | 52 +++++
 rtl/hilo_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: funct codes,
// FSM state encoding and the HI/LO-class opcode decoder.
package hilo_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    function automatic logic is_hilo_op(input logic [5:0] f);
        case (f)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_hilo_op = 1'b1;
            default:                            is_hilo_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative unsigned restoring divider: start loads the operands, then one
// quotient bit is produced per cycle for WIDTH cycles; done marks the last step.
module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] q, r, d;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   trial;

    // Bit WIDTH of the trial subtraction set means the partial remainder was smaller than the divisor.
    assign trial = {r, q[WIDTH-1]} - {1'b0, d};

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            q   <= dividend;
            r   <= '0;
            d   <= divisor;
            cnt <= CW'(WIDTH - 1);
            run <= 1'b1;
        end else if (run) begin
            q   <= {q[WIDTH-2:0], ~trial[WIDTH]};
            r   <= trial[WIDTH] ? {r[WIDTH-2:0], q[WIDTH-1]} : trial[WIDTH-1:0];
            cnt <= cnt - 1'b1;
            if (cnt == '0)
                run <= 1'b0;
        end
    end

    assign quot = q;
    assign rem  = r;
    assign done = run && (cnt == '0);

endmodule

// File: rtl/hilo_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; stalls EX1 for HI/LO ops while busy.
// Handshake: an op is consumed on a rising edge where valid && is_hilo_op(func) && !stall; a stalled op is held unchanged by EX1.
module hilo_sequencer
    import hilo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] mfout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           dbg_state
);

    state_t             state;
    logic [2:0]         cnt;
    logic [2*WIDTH-1:0] product;
    logic               neg_q, neg_r;
    logic               recognised, accept, is_signed;
    logic [2*WIDTH-1:0] ax, bx;
    logic [WIDTH-1:0]   div_a, div_b, quot, rem;
    logic               div_start, div_done;

    assign recognised = valid && is_hilo_op(func);
    assign accept     = recognised && !busy;
    assign stall      = recognised && busy;
    assign is_signed  = (func == FN_MULT) || (func == FN_DIV);
    assign div_start  = accept && ((func == FN_DIV) || (func == FN_DIVU));

    assign ax    = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign bx    = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign div_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign div_b = (is_signed && b[WIDTH-1]) ? -b : b;

    md_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_a),
        .divisor  (div_b),
        .quot     (quot),
        .rem      (rem),
        .done     (div_done)
    );

    always_comb begin
        mfout = '0;
        if (accept && func == FN_MFHI)
            mfout = hi;
        else if (accept && func == FN_MFLO)
            mfout = lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            product <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    case (func)
                        FN_MTHI: hi <= a;
                        FN_MTLO: lo <= a;
                        FN_MULT, FN_MULTU: begin
                            product <= ax * bx;
                            cnt     <= 3'(MUL_LAT - 1);
                            state   <= MUL;
                            busy    <= 1'b1;
                        end
                        FN_DIV, FN_DIVU: begin
                            // Divide by zero keeps the all-ones quotient unsigned; remainder sign restores A.
                            neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
                            neg_r <= is_signed && a[WIDTH-1];
                            state <= DIV;
                            busy  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= product;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: if (div_done) state <= FIX;
                FIX: begin
                    lo    <= neg_q ? -quot : quot;
                    hi    <= neg_r ? -rem : rem;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
